// File: rtl/crossing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crossing_pkg
// Purpose  : Phase codes, lamp patterns and default durations for the
//            pedestrian-crossing phase scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package crossing_pkg;

    typedef enum logic [2:0] {
        PH_CARS_GREEN      = 3'd0,
        PH_CARS_YELLOW     = 3'd1,
        PH_CLEAR_IN        = 3'd2,
        PH_PED_GO          = 3'd3,
        PH_CLEAR_OUT       = 3'd4,
        PH_CARS_RED_YELLOW = 3'd5
    } phase_e;

    typedef struct packed {
        logic road_red;
        logic road_yellow;
        logic road_green;
        logic ped_red;
        logic ped_green;
    } lamps_t;

    // Bit order: road R, Y, G, pedestrian R, G
    localparam lamps_t LAMPS_CARS_GREEN      = 5'b00110;
    localparam lamps_t LAMPS_CARS_YELLOW     = 5'b01010;
    localparam lamps_t LAMPS_ALL_RED         = 5'b10010;
    localparam lamps_t LAMPS_PED_GO          = 5'b10001;
    localparam lamps_t LAMPS_CARS_RED_YELLOW = 5'b11010;

    localparam int DEF_TICK_DIV     = 50000;
    localparam int DEF_T_MIN_GREEN  = 5;
    localparam int DEF_T_MAX_EXTEND = 4;
    localparam int DEF_T_YELLOW     = 3;
    localparam int DEF_T_CLEAR      = 1;
    localparam int DEF_T_PED_GREEN  = 6;
    localparam int DEF_T_RED_YELLOW = 3;
    localparam int DEF_CW           = 16;

    function automatic lamps_t phase_lamps(input phase_e ph);
        lamps_t l;
        case (ph)
            PH_CARS_GREEN:      l = LAMPS_CARS_GREEN;
            PH_CARS_YELLOW:     l = LAMPS_CARS_YELLOW;
            PH_PED_GO:          l = LAMPS_PED_GO;
            PH_CARS_RED_YELLOW: l = LAMPS_CARS_RED_YELLOW;
            default:            l = LAMPS_ALL_RED;
        endcase
        return l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : tick_prescaler
// Purpose  : Divides the clock into a one-cycle timing tick; restartable.
// Revision : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 4,
    parameter int CW       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (i_restart || (cnt_q == C_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/crossing_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : crossing_phase_scheduler
// Purpose  : Pedestrian-crossing phase sequencer with request latch,
//            minimum green and detector-driven green extension.
// Revision : 1.0 - initial release
// ============================================================================
module crossing_phase_scheduler
    import crossing_pkg::*;
#(
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int T_MIN_GREEN  = DEF_T_MIN_GREEN,
    parameter int T_MAX_EXTEND = DEF_T_MAX_EXTEND,
    parameter int T_YELLOW     = DEF_T_YELLOW,
    parameter int T_CLEAR      = DEF_T_CLEAR,
    parameter int T_PED_GREEN  = DEF_T_PED_GREEN,
    parameter int T_RED_YELLOW = DEF_T_RED_YELLOW,
    parameter int CW           = DEF_CW
) (
    input  logic       CLK_PCB,
    input  logic       nRST_PCB,
    input  logic       ROAD_DET,
    input  logic       PED_BUTT,
    output logic       ROAD_RED,
    output logic       ROAD_YELLOW,
    output logic       ROAD_GREEN,
    output logic       PED_RED,
    output logic       PED_GREEN,
    output logic [3:0] LED
);

    localparam logic [CW-1:0] C_MIN_GREEN  = CW'(T_MIN_GREEN);
    localparam logic [CW-1:0] C_MAX_EXTEND = CW'(T_MAX_EXTEND);
    localparam logic [CW-1:0] C_YELLOW     = CW'(T_YELLOW);
    localparam logic [CW-1:0] C_CLEAR      = CW'(T_CLEAR);
    localparam logic [CW-1:0] C_PED_GREEN  = CW'(T_PED_GREEN);
    localparam logic [CW-1:0] C_RED_YELLOW = CW'(T_RED_YELLOW);

    logic clk;
    logic rst;
    assign clk = CLK_PCB;
    assign rst = nRST_PCB;

    logic butt_s1_q, butt_s1_d, butt_s2_q, butt_s2_d, butt_prev_q, butt_prev_d;
    logic det_s1_q, det_s1_d, det_s2_q, det_s2_d;
    logic req_q, req_d;
    phase_e phase_q, phase_d;
    logic [CW-1:0] phase_cnt_q, phase_cnt_d;
    logic [CW-1:0] ext_cnt_q, ext_cnt_d;
    lamps_t lamps_q, lamps_d;

    logic tick;
    logic phase_entry;
    logic butt_rise;
    logic green_met;
    logic ext_counting;
    logic ext_done;
    logic [CW-1:0] phase_len;
    phase_e phase_next;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CW       (CW)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .i_restart (phase_entry),
        .o_tick    (tick)
    );

    always_comb begin
        phase_len  = C_YELLOW;
        phase_next = PH_CARS_GREEN;
        case (phase_q)
            PH_CARS_YELLOW:     begin phase_len = C_YELLOW;     phase_next = PH_CLEAR_IN;        end
            PH_CLEAR_IN:        begin phase_len = C_CLEAR;      phase_next = PH_PED_GO;          end
            PH_PED_GO:          begin phase_len = C_PED_GREEN;  phase_next = PH_CLEAR_OUT;       end
            PH_CLEAR_OUT:       begin phase_len = C_CLEAR;      phase_next = PH_CARS_RED_YELLOW; end
            PH_CARS_RED_YELLOW: begin phase_len = C_RED_YELLOW; phase_next = PH_CARS_GREEN;      end
            default:            begin phase_len = C_YELLOW;     phase_next = PH_CARS_YELLOW;     end
        endcase
    end

    always_comb begin
        butt_s1_d   = PED_BUTT;
        butt_s2_d   = butt_s1_q;
        butt_prev_d = butt_s2_q;
        det_s1_d    = ROAD_DET;
        det_s2_d    = det_s1_q;

        butt_rise = butt_s2_q & ~butt_prev_q;

        // Elapsed-tick tests include the tick landing on this edge, so a
        // threshold is acted on at the very edge it is reached.
        green_met    = (phase_cnt_q >= C_MIN_GREEN) ||
                       (tick && (phase_cnt_q == C_MIN_GREEN - 1'b1));
        ext_counting = req_q && green_met && det_s2_q;
        ext_done     = (ext_cnt_q >= C_MAX_EXTEND) ||
                       (tick && ext_counting && (ext_cnt_q == C_MAX_EXTEND - 1'b1));

        phase_d     = phase_q;
        phase_cnt_d = phase_cnt_q;
        ext_cnt_d   = ext_cnt_q;
        req_d       = req_q;

        if (phase_q == PH_CARS_GREEN) begin
            if (tick && (phase_cnt_q < C_MIN_GREEN)) begin
                phase_cnt_d = phase_cnt_q + 1'b1;
            end
            if (tick && ext_counting && (ext_cnt_q < C_MAX_EXTEND)) begin
                ext_cnt_d = ext_cnt_q + 1'b1;
            end
            if (butt_rise) begin
                req_d = 1'b1;
            end
            if (req_q && green_met && (!det_s2_q || ext_done)) begin
                phase_d = PH_CARS_YELLOW;
            end
        end else begin
            if (tick) begin
                if (phase_cnt_q == phase_len - 1'b1) begin
                    phase_d = phase_next;
                end else begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end
            end
            if (butt_rise && ((phase_q == PH_CLEAR_OUT) || (phase_q == PH_CARS_RED_YELLOW))) begin
                req_d = 1'b1;
            end
        end

        phase_entry = (phase_d != phase_q);
        if (phase_entry) begin
            phase_cnt_d = '0;
            ext_cnt_d   = '0;
        end
        // Entering yellow consumes the request, winning over a same-edge press.
        if (phase_entry && (phase_d == PH_CARS_YELLOW)) begin
            req_d = 1'b0;
        end

        lamps_d = phase_lamps(phase_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            butt_s1_q   <= 1'b0;
            butt_s2_q   <= 1'b0;
            butt_prev_q <= 1'b0;
            det_s1_q    <= 1'b0;
            det_s2_q    <= 1'b0;
            req_q       <= 1'b0;
            phase_q     <= PH_CARS_GREEN;
            phase_cnt_q <= '0;
            ext_cnt_q   <= '0;
            lamps_q     <= LAMPS_CARS_GREEN;
        end else begin
            butt_s1_q   <= butt_s1_d;
            butt_s2_q   <= butt_s2_d;
            butt_prev_q <= butt_prev_d;
            det_s1_q    <= det_s1_d;
            det_s2_q    <= det_s2_d;
            req_q       <= req_d;
            phase_q     <= phase_d;
            phase_cnt_q <= phase_cnt_d;
            ext_cnt_q   <= ext_cnt_d;
            lamps_q     <= lamps_d;
        end
    end

    assign ROAD_RED    = lamps_q.road_red;
    assign ROAD_YELLOW = lamps_q.road_yellow;
    assign ROAD_GREEN  = lamps_q.road_green;
    assign PED_RED     = lamps_q.ped_red;
    assign PED_GREEN   = lamps_q.ped_green;
    assign LED         = {req_q, phase_q};

endmodule
`default_nettype wire

// File: doc/crossing_phase_scheduler.md
# crossing_phase_scheduler

Phase sequencer for the pedestrian-crossing light set. It latches pedestrian-button requests and enforces a minimum car-green time. While cars are detected it extends green up to a bound, then steps road and pedestrian lamps through a timed yellow / clearance / walk / red-yellow cycle. It sits directly under `top`, drives the lamp outputs and LED status, and replaces ad-hoc timing in the top level.

## Interface
- `TICK_DIV`, 50000: clock cycles per timing tick (1 ms at 50 MHz); ≥1
- `T_MIN_GREEN`, 5: minimum car-green, ticks; ≥1
- `T_MAX_EXTEND`, 4: maximum green extension while `ROAD_DET`=1 after a request, ticks; ≥1
- `T_YELLOW`, 3 / `T_CLEAR`, 1 / `T_PED_GREEN`, 6 / `T_RED_YELLOW`, 3: phase lengths, ticks; each ≥1
- `CW`, 16: tick/phase counter width
- `CLK_PCB` in 1: system clock
- `nRST_PCB` in 1: reset, asynchronous, active-high (1 = reset)
- `ROAD_DET` in 1: car present, asynchronous
- `PED_BUTT` in 1: pedestrian button, asynchronous, active-high
- `ROAD_RED`, `ROAD_YELLOW`, `ROAD_GREEN` out 1 each: road lamps
- `PED_RED`, `PED_GREEN` out 1 each: pedestrian lamps
- `LED` out 4: [2:0] phase code, [3] request pending

## Operation
- Phases and codes: CARS_GREEN=0, CARS_YELLOW=1, CLEAR_IN=2, PED_GO=3, CLEAR_OUT=4, CARS_RED_YELLOW=5.
- Lamps:
  - CARS_GREEN: G + PED_RED.
  - CARS_YELLOW: Y + PED_RED.
  - CLEAR_IN / CLEAR_OUT: R + PED_RED.
  - PED_GO: R + PED_GREEN.
  - CARS_RED_YELLOW: R + Y + PED_RED.
  - PED_GREEN and ROAD_GREEN are never both 1.
- Request latch `req_pending`:
  - `PED_BUTT` is 2-flop synchronised; a rising edge sets `req_pending` in CARS_GREEN, CLEAR_OUT and CARS_RED_YELLOW.
  - Edges in CARS_YELLOW, CLEAR_IN and PED_GO are ignored.
  - Cleared on entry to CARS_YELLOW.
  - A held button produces one request only.
- CARS_GREEN exit to CARS_YELLOW requires all of:
  - `req_pending`=1;
  - green elapsed ≥ T_MIN_GREEN ticks;
  - (synchronised `ROAD_DET`=0 or extension elapsed ≥ T_MAX_EXTEND ticks).
- Extension counter:
  - Counts ticks only while `req_pending`, min-green met, and `ROAD_DET`=1.
  - Cleared on leaving CARS_GREEN.
- Timed phases advance after exactly their T ticks: CARS_YELLOW→CLEAR_IN→PED_GO→CLEAR_OUT→CARS_RED_YELLOW→CARS_GREEN.
- Without a request, CARS_GREEN holds indefinitely. The green counter saturates at T_MIN_GREEN, so there is no wrap.
- Reset (async, any phase): CARS_GREEN, `req_pending`=0, all counters and synchronisers 0.

## Timing
- Reset values: ROAD_GREEN=1, PED_RED=1, ROAD_RED=ROAD_YELLOW=PED_GREEN=0, LED=4'b0000.
- Lamps and LED are registered and update on the same edge as the phase register.
- Button latency: `PED_BUTT` rise to `req_pending`=1 is 3 clock edges (2 sync + 1 edge-detect/latch).
- `ROAD_DET` latency: 2 edges of synchronisation.
- Prescaler and phase timer restart on every phase entry. A timed phase therefore lasts exactly T×TICK_DIV cycles.
- CARS_GREEN exit occurs on the first edge where the exit condition holds. If the button latches after min-green is met with `ROAD_DET`=0, CARS_YELLOW is entered on the edge after `req_pending` rises.
- Simultaneous button edge and CARS_GREEN exit: the request is consumed. Clearing has priority, so no second cycle is queued.

## Structure
- `crossing_pkg`: phase enum/codes, lamp-pattern constants, default durations.
- Sub-module `tick_prescaler`: counter 0..TICK_DIV-1, one-cycle `tick`, synchronous `restart` input.
- The FSM, request latch, synchronisers and phase/extension counters live in `crossing_phase_scheduler`. Target size: 150–300 lines.

## Test plan
All scenarios use TICK_DIV=4, defaults otherwise. Cycle counts are measured from reset release.
- Idle: reset, no inputs, 300 cycles → ROAD_GREEN=1, PED_RED=1, LED=0000 throughout.
- Full cycle: `PED_BUTT` pulse at cycle 100, `ROAD_DET`=0 →
  - `LED[3]`=1 at +3 edges; CARS_YELLOW (LED=0001) at +4.
  - Phase lengths: yellow 12, CLEAR_IN 4, PED_GO 24 (PED_GREEN=1, ROAD_RED=1), CLEAR_OUT 4, red-yellow 12 cycles, then CARS_GREEN.
- Early press: `PED_BUTT` pulse at cycle 2 → CARS_YELLOW entered at cycle 20 (min green), not before.
- Extension: press at cycle 100 with `ROAD_DET`=1 held → yellow is delayed 16 cycles. Repeat with `ROAD_DET` dropped after 6 cycles → yellow 3 edges after the drop.
- Request filtering: presses during PED_GO → LED[3] stays 0, return to green holds. A press during CARS_RED_YELLOW → LED[3]=1, new yellow after 20 green cycles.
- Async reset: assert `nRST_PCB` mid-PED_GO between clock edges → lamps show reset values immediately, without a clock edge. After release, a new request is required.
